// File: rtl/image_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : image_job_dispatcher
// Description : Upstream stage of the image-filter main process. Host jobs
//               (X,Y,Z coordinate triples) enter a small FIFO through a
//               valid/ready port. Jobs are launched one at a time: a one-cycle
//               start pulse with X/Y/Z held stable, a wait for done, then
//               retirement before the next launch.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid_i   host offers a job
//   req_ready_o   FIFO can accept (not full)
//   req_x/y/z_i   job coordinates
//   start_o       one-cycle launch pulse to the main process
//   x/y/z_o       coordinates of the current job, held until the next launch
//   done_i        main process finished (only looked at while waiting)
//   busy_o        job in flight or jobs queued
//   job_done_o    one-cycle pulse per normally retired job
//   job_count_o   retired-job counter, wraps 255 -> 0
//   fifo_level_o  number of queued jobs
//   timeout_o     one-cycle pulse on watchdog abort
// Configuration
//   JOB_WATCHDOG_EN : when defined, a job waiting TIMEOUT_CYCLES cycles
//                     without done is aborted (timeout_o pulses, job not
//                     counted). When undefined, waiting lasts until done and
//                     timeout_o is tied low.
// ============================================================================
module image_job_dispatcher #(
    parameter int COORD_W        = 7,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [COORD_W-1:0]       req_x_i,
    input  logic [COORD_W-1:0]       req_y_i,
    input  logic [COORD_W-1:0]       req_z_i,
    output logic                     start_o,
    output logic [COORD_W-1:0]       x_o,
    output logic [COORD_W-1:0]       y_o,
    output logic [COORD_W-1:0]       z_o,
    input  logic                     done_i,
    output logic                     busy_o,
    output logic                     job_done_o,
    output logic [7:0]               job_count_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     timeout_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int JOB_W = 3 * COORD_W;
    localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(DEPTH);

    // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of
    // two; the watchdog counter is 16 bits wide.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_param_check
        $error("image_job_dispatcher: illegal DEPTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Job FIFO
    // ------------------------------------------------------------------
    logic [JOB_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [JOB_W-1:0] w_head;

    state_t           state_q;

    // Full is taken from the registered level, so a pop on the same edge
    // never frees a slot for that edge's push.
    assign w_full = (level_q == C_DEPTH);
    assign w_push = req_valid_i & ~w_full;
    assign w_pop  = (state_q == ST_IDLE) && (level_q != '0);
    assign w_head = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        if (w_push && !w_pop) begin
            level_d = level_q + 1'b1;
        end else if (!w_push && w_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {req_x_i, req_y_i, req_z_i};
        end
    end

    // ------------------------------------------------------------------
    // Launch / wait / retire sequencer with registered Moore outputs
    // ------------------------------------------------------------------
    logic               start_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [COORD_W-1:0] z_q;
    logic               job_done_q;
    logic [7:0]         job_count_q;
`ifdef JOB_WATCHDOG_EN
    localparam logic [15:0] C_WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]        wd_cnt_q;
    logic               timeout_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            job_done_q  <= 1'b0;
            job_count_q <= '0;
`ifdef JOB_WATCHDOG_EN
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_pop) begin
                        state_q <= ST_LAUNCH;
                        start_q <= 1'b1;
                        {x_q, y_q, z_q} <= w_head;
                    end
                end
                ST_LAUNCH: begin
                    state_q <= ST_WAIT;
                    start_q <= 1'b0;
`ifdef JOB_WATCHDOG_EN
                    wd_cnt_q <= '0;
`endif
                end
                ST_WAIT: begin
                    // done takes priority over a coinciding watchdog expiry
                    if (done_i) begin
                        state_q    <= ST_RETIRE;
                        job_done_q <= 1'b1;
                    end
`ifdef JOB_WATCHDOG_EN
                    else if (wd_cnt_q == C_WD_LAST) begin
                        state_q   <= ST_RETIRE;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end
                ST_RETIRE: begin
                    state_q    <= ST_IDLE;
                    job_done_q <= 1'b0;
`ifdef JOB_WATCHDOG_EN
                    timeout_q  <= 1'b0;
`endif
                    // job_done_q is high here only for a normal retirement
                    if (job_done_q) begin
                        job_count_q <= job_count_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = ~w_full;
    assign start_o      = start_q;
    assign x_o          = x_q;
    assign y_o          = y_q;
    assign z_o          = z_q;
    assign busy_o       = (state_q != ST_IDLE) || (level_q != '0);
    assign job_done_o   = job_done_q;
    assign job_count_o  = job_count_q;
    assign fifo_level_o = level_q;
`ifdef JOB_WATCHDOG_EN
    assign timeout_o    = timeout_q;
`else
    assign timeout_o    = 1'b0;
`endif

endmodule
`default_nettype wire
